// File: rtl/imm_field_encoder.sv
// imm_field_encoder: narrows a 64-bit signed value into a 9/12/19/26-bit
// immediate field. An optional divide-by-4 is applied first. Out-of-range
// values saturate to the largest or smallest value of the selected width.
// Results are held in a 2-entry in-order FIFO with valid/ready handshakes.
// A saturating counter tracks overflowing or misaligned transactions.
//
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   in_valid/in_ready   input handshake; in_ready is 1 only when the FIFO has a free slot
//   in_value            signed value to narrow
//   in_sel              field width: 00=9, 01=12, 10=19, 11=26
//   in_scale            1 = byte offset, arithmetic shift right by 2 first
//   out_valid/out_ready output handshake on the FIFO head
//   out_field           encoded field, zero above the selected width
//   out_fits            value representable in the selected width
//   out_misaligned      in_scale=1 and the low two bits are non-zero
//   clr_count           synchronous clear of ovf_count (wins over increment)
//   ovf_count           saturating count of overflowing/misaligned inputs
module imm_field_encoder #(
    parameter int unsigned OVF_CNT_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [63:0]              in_value,
    input  logic [1:0]               in_sel,
    input  logic                     in_scale,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [25:0]              out_field,
    output logic                     out_fits,
    output logic                     out_misaligned,
    input  logic                     clr_count,
    output logic [OVF_CNT_WIDTH-1:0] ovf_count
);

    localparam int unsigned FIELD_W = 26;

    typedef struct packed {
        logic [FIELD_W-1:0] field;
        logic               fits;
        logic               mis;
    } entry_t;

    logic signed [63:0] val_s;
    logic signed [63:0] v_s;
    logic signed [63:0] hi_s;
    logic signed [63:0] lo_s;
    logic [4:0]         w_c;
    logic [FIELD_W-1:0] half_c;
    logic [FIELD_W-1:0] mask_c;
    entry_t             res_c;

    entry_t                   head_q, head_d;
    entry_t                   tail_q, tail_d;
    logic [1:0]               cnt_q, cnt_d;
    logic [1:0]               cnt_pop;
    logic [OVF_CNT_WIDTH-1:0] ovf_q, ovf_d;
    logic                     push;
    logic                     pop;

    assign val_s = $signed(in_value);

    // Narrowing: range check against [-2^(W-1), 2^(W-1)-1], then clamp
    always_comb begin
        w_c = 5'd9;
        case (in_sel)
            2'b00:   w_c = 5'd9;
            2'b01:   w_c = 5'd12;
            2'b10:   w_c = 5'd19;
            default: w_c = 5'd26;
        endcase
        v_s    = in_scale ? (val_s >>> 2) : val_s;
        hi_s   = (64'sd1 <<< (w_c - 5'd1)) - 64'sd1;
        lo_s   = ~hi_s;
        half_c = FIELD_W'(26'd1 << (w_c - 5'd1));
        // for W=26 the shift wraps to 0, so the subtraction gives all ones
        mask_c = FIELD_W'((26'd1 << w_c) - 26'd1);

        res_c      = '0;
        res_c.fits = (v_s <= hi_s) && (v_s >= lo_s);
        res_c.mis  = in_scale & (|in_value[1:0]);
        if (res_c.fits) begin
            res_c.field = v_s[FIELD_W-1:0] & mask_c;
        end else if (v_s[63]) begin
            res_c.field = half_c;
        end else begin
            res_c.field = half_c - FIELD_W'(1);
        end
    end

    assign in_ready  = reset_n & (cnt_q != 2'd2);
    assign out_valid = (cnt_q != 2'd0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // FIFO next state: shift on pop, then write into the first free slot
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        cnt_pop = cnt_q - 2'(pop);
        cnt_d   = cnt_pop + 2'(push);
        if (pop) begin
            head_d = tail_q;
        end
        if (push) begin
            if (cnt_pop == 2'd0) begin
                head_d = res_c;
            end else begin
                tail_d = res_c;
            end
        end
    end

    // Overflow counter; clear has priority over increment
    always_comb begin
        ovf_d = ovf_q;
        if (clr_count) begin
            ovf_d = '0;
        end else if (push && (!res_c.fits || res_c.mis) && (ovf_q != '1)) begin
            ovf_d = ovf_q + OVF_CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
            ovf_q  <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
            ovf_q  <= ovf_d;
        end
    end

    assign out_field      = out_valid ? head_q.field : '0;
    assign out_fits       = out_valid & head_q.fits;
    assign out_misaligned = out_valid & head_q.mis;
    assign ovf_count      = ovf_q;

endmodule

// File: tb/tb_imm_field_encoder.sv
// Bench for imm_field_encoder: directed vectors, a backpressure sequence,
// randomized traffic against a clamp-based model, counter saturation on a
// 2-bit instance, and a mid-operation reset.
module tb_imm_field_encoder;

    logic        clk;
    logic        reset_n;
    logic        in_valid, in_ready, in_scale, out_valid, out_ready;
    logic [63:0] in_value;
    logic [1:0]  in_sel;
    logic [25:0] out_field;
    logic        out_fits, out_misaligned, clr_count;
    logic [15:0] ovf_count;

    logic        v2_valid, v2_ready, v2_scale, o2_valid, o2_ready;
    logic [63:0] v2_value;
    logic [1:0]  v2_sel;
    logic [25:0] o2_field;
    logic        o2_fits, o2_mis, clr2;
    logic [1:0]  ovf2;

    int n_chk  = 0;
    int n_fail = 0;

    imm_field_encoder #(.OVF_CNT_WIDTH(16)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_value(in_value),
        .in_sel(in_sel), .in_scale(in_scale),
        .out_valid(out_valid), .out_ready(out_ready), .out_field(out_field),
        .out_fits(out_fits), .out_misaligned(out_misaligned),
        .clr_count(clr_count), .ovf_count(ovf_count)
    );

    imm_field_encoder #(.OVF_CNT_WIDTH(2)) dut2 (
        .clk(clk), .reset_n(reset_n),
        .in_valid(v2_valid), .in_ready(v2_ready), .in_value(v2_value),
        .in_sel(v2_sel), .in_scale(v2_scale),
        .out_valid(o2_valid), .out_ready(o2_ready), .out_field(o2_field),
        .out_fits(o2_fits), .out_misaligned(o2_mis),
        .clr_count(clr2), .ovf_count(ovf2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [25:0] f;
        logic        ft;
        logic        ms;
    } exp_t;

    typedef struct {
        longint      val;
        logic [1:0]  sel;
        logic        sc;
        logic [25:0] f;
        logic        ft;
        logic        ms;
        int          ovf;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic int width_of(input logic [1:0] sel);
        case (sel)
            2'b00:   return 9;
            2'b01:   return 12;
            2'b10:   return 19;
            default: return 26;
        endcase
    endfunction

    // Reference: scale, clamp to the signed range of W bits, keep W low bits
    function automatic exp_t model(input longint v, input logic [1:0] sel, input logic sc);
        exp_t   e;
        int     w;
        longint vp, lo, hi, sat;
        w    = width_of(sel);
        vp   = sc ? (v >>> 2) : v;
        lo   = -(longint'(1) << (w - 1));
        hi   = -lo - 1;
        e.ft = (vp >= lo) && (vp <= hi);
        sat  = (vp < lo) ? lo : ((vp > hi) ? hi : vp);
        e.f  = 26'(sat & ((longint'(1) << w) - 1));
        e.ms = sc && (v[1:0] != 2'b00);
        return e;
    endfunction

    task automatic drive(input longint v, input logic [1:0] sel, input logic sc);
        in_value = 64'(v);
        in_sel   = sel;
        in_scale = sc;
    endtask

    vec_t   vt[6];
    exp_t   q[$];
    exp_t   e;
    logic [25:0] got[$];
    int     mdl_ovf;
    longint v, b;

    initial begin
        reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; clr_count = 1'b0;
        in_value = '0; in_sel = '0; in_scale = 1'b0;
        v2_valid = 1'b0; o2_ready = 1'b1; clr2 = 1'b0;
        v2_value = 64'd1000; v2_sel = 2'b00; v2_scale = 1'b0;

        vt[0] = '{255,   2'b00, 1'b0, 26'h0FF,     1'b1, 1'b0, 0};
        vt[1] = '{256,   2'b00, 1'b0, 26'h0FF,     1'b0, 1'b0, 1};
        vt[2] = '{-2048, 2'b01, 1'b0, 26'h800,     1'b1, 1'b0, 1};
        vt[3] = '{-2049, 2'b01, 1'b0, 26'h800,     1'b0, 1'b0, 2};
        vt[4] = '{-8,    2'b11, 1'b1, 26'h3FFFFFE, 1'b1, 1'b0, 2};
        vt[5] = '{6,     2'b11, 1'b1, 26'h0000001, 1'b1, 1'b1, 3};

        // Reset state
        #3;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_outputs", {out_field, out_fits, out_misaligned}, 0);
        chk("rst_ovf", ovf_count, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        #1 chk("post_rst_in_ready", in_ready, 1);

        // Saturation of a 2-bit counter, then clear beating an increment
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk); v2_valid = 1'b1;
            @(posedge clk); #1;
            chk("ovf2_count", ovf2, (k > 3) ? 3 : k);
        end
        @(negedge clk); clr2 = 1'b1;
        @(posedge clk); #1;
        chk("ovf2_clear_wins", ovf2, 0);
        @(negedge clk); v2_valid = 1'b0; clr2 = 1'b0;

        // Directed vectors; each result checked one cycle after acceptance
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            in_valid = 1'b1; out_ready = 1'b1;
            drive(vt[i].val, vt[i].sel, vt[i].sc);
            @(posedge clk); #1;
            in_valid = 1'b0;
            chk("vec_valid", out_valid, 1);
            chk("vec_field", out_field, vt[i].f);
            chk("vec_fits", out_fits, vt[i].ft);
            chk("vec_mis", out_misaligned, vt[i].ms);
            chk("vec_ovf", ovf_count, vt[i].ovf);
        end
        @(posedge clk); #1;
        chk("drain_valid", out_valid, 0);
        chk("drain_zero_outputs", {out_field, out_fits, out_misaligned}, 0);

        // Backpressure: A, B accepted, C held until the consumer drains
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; drive(1, 2'b00, 1'b0);
        @(negedge clk);
        chk("bp_ready_one", in_ready, 1);
        drive(2, 2'b00, 1'b0);
        @(negedge clk);
        chk("bp_full", in_ready, 0);
        chk("bp_head_a", out_field, 1);
        drive(3, 2'b00, 1'b0);
        @(negedge clk);
        chk("bp_hold_ready", in_ready, 0);
        chk("bp_hold_head", out_field, 1);
        out_ready = 1'b1;
        begin
            logic c_sent;
            c_sent = 1'b0;
            for (int cy = 0; cy < 12 && got.size() < 3; cy++) begin
                if (out_valid) got.push_back(out_field);
                if (in_valid && in_ready) c_sent = 1'b1;
                @(posedge clk); #1;
                if (c_sent) in_valid = 1'b0;
                @(negedge clk);
            end
        end
        chk("bp_count", got.size(), 3);
        for (int i = 0; i < got.size() && i < 3; i++) chk("bp_order", got[i], i + 1);
        chk("bp_no_dup", out_valid, 0);

        // Randomized traffic against the model
        mdl_ovf = 3;
        for (int c = 0; c < 600; c++) begin
            int  sz;
            @(negedge clk);
            chk("rnd_ovf", ovf_count, mdl_ovf);
            chk("rnd_in_ready", in_ready, q.size() < 2);
            chk("rnd_out_valid", out_valid, q.size() != 0);
            if (q.size() != 0)
                chk("rnd_head", {out_field, out_fits, out_misaligned}, {q[0].f, q[0].ft, q[0].ms});
            else
                chk("rnd_idle_zero", {out_field, out_fits, out_misaligned}, 0);

            in_valid  = ($urandom_range(0, 2) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            clr_count = ($urandom_range(0, 15) == 0);
            in_sel    = 2'($urandom_range(0, 3));
            in_scale  = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 2))
                0: v = longint'({$urandom, $urandom});
                1: v = longint'($signed(16'($urandom)));
                default: begin
                    b = longint'(1) << (width_of(in_sel) - 1);
                    if (in_scale) b = b * 4;
                    v = (($urandom_range(0, 1) != 0) ? b : -b) + longint'($urandom_range(0, 16)) - 8;
                end
            endcase
            in_value = 64'(v);

            sz = q.size();
            e  = model(v, in_sel, in_scale);
            if (sz != 0 && out_ready) void'(q.pop_front());
            if (in_valid && sz < 2) q.push_back(e);
            if (clr_count) mdl_ovf = 0;
            else if (in_valid && sz < 2 && (!e.ft || e.ms) && mdl_ovf < 65535) mdl_ovf++;
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1; clr_count = 1'b0;
        repeat (3) @(negedge clk);
        q.delete();

        // Reset with two entries buffered
        out_ready = 1'b0; in_valid = 1'b1; drive(1000, 2'b00, 1'b0);
        @(negedge clk);
        drive(2000, 2'b00, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        chk("mid_full", in_ready, 0);
        chk("mid_ovf_nonzero", ovf_count != 0, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_ovf", ovf_count, 0);
        chk("mid_rst_ready", in_ready, 0);
        chk("mid_rst_outputs", {out_field, out_fits, out_misaligned}, 0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("rel_ready", in_ready, 1);
        chk("rel_valid", out_valid, 0);
        in_valid = 1'b1; out_ready = 1'b1; drive(5, 2'b00, 1'b0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("rel_latency_valid", out_valid, 1);
        chk("rel_latency_field", out_field, 5);
        chk("rel_ovf", ovf_count, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
